// File: rtl/led_display_row_scanner_if.sv
// Frame-memory read port and row-transfer port of the LED row scanner.
// The scanner side uses the master modport; memory and display driver use slave.
interface led_display_row_scanner_if #(
    parameter int NUM_PLANES = 4,
    parameter int ROW_W      = 96
);
    localparam int AW = $clog2(NUM_PLANES) + 4;
    typedef logic [ROW_W-1:0] rgb_row_t;

    logic          mem_rd_en_out;
    logic [AW-1:0] mem_addr_out;
    rgb_row_t      mem_data_in;
    logic          row_valid_out;
    rgb_row_t      row_out;
    logic [3:0]    row_address_out;
    logic          row_ready_in;

    modport master (
        output mem_rd_en_out, mem_addr_out, row_valid_out, row_out, row_address_out,
        input  mem_data_in, row_ready_in
    );
    modport slave (
        input  mem_rd_en_out, mem_addr_out, row_valid_out, row_out, row_address_out,
        output mem_data_in, row_ready_in
    );
endinterface

// File: rtl/led_display_row_scanner.sv
// Binary-code-modulation row scanner: reads {plane,row} words from frame memory and
// hands them to the display driver, dwelling BASE_TICKS << plane cycles per row.
module led_display_row_scanner #(
    parameter int NUM_PLANES = 4,
    parameter int BASE_TICKS = 64,
    parameter int NUM_ROWS   = 16,
    parameter int ROW_W      = 96
) (
    input  logic clk_in,
    input  logic reset_in,
    input  logic enable_in,
    output logic frame_done_out,
    led_display_row_scanner_if.master bus
);
    localparam int PW = $clog2(NUM_PLANES);
    localparam int DW = $clog2(BASE_TICKS << (NUM_PLANES - 1)) + 1;

    typedef enum logic [2:0] {IDLE, READ, CAPTURE, WAIT_READY, SEND, DWELL} state_t;

    state_t           state;
    logic [PW-1:0]    plane, nxt_plane;
    logic [3:0]       row, nxt_row;
    logic [DW-1:0]    dwell;
    logic [ROW_W-1:0] row_buf, pf_buf, send_data;
    logic             pf_valid, rd_q;
    logic             last_row, last_plane, send_now;

    assign last_row   = (row == 4'(NUM_ROWS - 1));
    assign last_plane = (plane == PW'(NUM_PLANES - 1));
    assign nxt_row    = last_row ? 4'd0 : row + 4'd1;
    assign nxt_plane  = !last_row ? plane : (last_plane ? '0 : plane + PW'(1));

    // A freshly captured word can go out on the same edge it is registered, which
    // keeps enable-to-strobe at three cycles when the driver is already ready.
    assign send_now  = (state == CAPTURE || state == WAIT_READY) &&
                       bus.row_ready_in && (dwell == '0);
    assign send_data = (state == CAPTURE) ? bus.mem_data_in : row_buf;

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state               <= IDLE;
            plane               <= '0;
            row                 <= '0;
            dwell               <= '0;
            row_buf             <= '0;
            pf_buf              <= '0;
            pf_valid            <= 1'b0;
            rd_q                <= 1'b0;
            frame_done_out      <= 1'b0;
            bus.mem_rd_en_out   <= 1'b0;
            bus.mem_addr_out    <= '0;
            bus.row_valid_out   <= 1'b0;
            bus.row_out         <= '0;
            bus.row_address_out <= '0;
        end else begin
            bus.mem_rd_en_out <= 1'b0;
            bus.row_valid_out <= 1'b0;
            frame_done_out    <= 1'b0;
            rd_q              <= bus.mem_rd_en_out;
            if (dwell != '0) dwell <= dwell - 1'b1;

            case (state)
                IDLE: if (enable_in) begin
                    bus.mem_rd_en_out <= 1'b1;
                    bus.mem_addr_out  <= {plane, row};
                    state             <= READ;
                end
                READ: state <= CAPTURE;
                CAPTURE: begin
                    row_buf <= bus.mem_data_in;
                    state   <= WAIT_READY;
                end
                WAIT_READY: ;
                SEND: begin
                    // Prefetch the next row so its word is waiting when the dwell ends.
                    pf_valid <= 1'b0;
                    state    <= DWELL;
                    if (enable_in) begin
                        bus.mem_rd_en_out <= 1'b1;
                        bus.mem_addr_out  <= {nxt_plane, nxt_row};
                    end
                end
                DWELL: begin
                    if (rd_q) begin
                        pf_buf   <= bus.mem_data_in;
                        pf_valid <= 1'b1;
                    end
                    if (dwell == DW'(1)) begin
                        plane          <= nxt_plane;
                        row            <= nxt_row;
                        frame_done_out <= last_row && last_plane;
                        if (enable_in && pf_valid) begin
                            row_buf <= pf_buf;
                            state   <= WAIT_READY;
                        end else begin
                            state   <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            if (send_now) begin
                bus.row_valid_out   <= 1'b1;
                bus.row_out         <= send_data;
                bus.row_address_out <= row;
                dwell               <= DW'(BASE_TICKS) << plane;
                state               <= SEND;
            end
        end
    end
endmodule

// File: tb/tb_led_display_row_scanner.sv
// Randomized bench for the LED row scanner: random frame memory and driver busy
// times, checked against a scan-order model of position, data and strobe spacing.
module tb_led_display_row_scanner;
    localparam int NP = 4, BT = 64, NR = 16, RW = 96;

    logic clk_in = 1'b0, reset_in = 1'b1, enable_in = 1'b0;
    logic frame_done_out;

    led_display_row_scanner_if #(.NUM_PLANES(NP), .ROW_W(RW)) bus();

    led_display_row_scanner #(.NUM_PLANES(NP), .BASE_TICKS(BT), .NUM_ROWS(NR), .ROW_W(RW)) dut (
        .clk_in(clk_in), .reset_in(reset_in), .enable_in(enable_in),
        .frame_done_out(frame_done_out), .bus(bus)
    );

    always #5 clk_in = ~clk_in;

    int vectors = 0, miscompares = 0;
    int cyc = 0;
    logic [RW-1:0] mem [64];

    int          s_cyc[$], r_cyc[$], fd_cyc[$];
    logic [3:0]  s_addr[$];
    logic [5:0]  r_addr[$];
    logic [RW-1:0] s_data[$];
    int  prot_err = 0, rdy_rise = 0;
    bit  prev_valid = 0, prev_ready = 0;
    int  busy = 0, busy_len = 64;
    bit  hold_low = 0, nxt_ready = 1;
    int  model_pos = 0, last_c = 0, last_p = 0;

    always @(posedge clk_in) cyc++;

    always @(posedge clk_in)
        bus.mem_data_in <= bus.mem_rd_en_out ? mem[bus.mem_addr_out] : {$urandom(), $urandom(), $urandom()};

    always @(posedge clk_in) begin
        #1;
        bus.row_ready_in = nxt_ready;
    end

    // Monitor plus display-driver model: busy for busy_len cycles counting the strobe cycle.
    always @(negedge clk_in) begin
        if (reset_in) begin
            if (bus.row_valid_out) prot_err++;
            busy = 0;
        end else begin
            if (bus.row_valid_out) begin
                s_cyc.push_back(cyc);
                s_addr.push_back(bus.row_address_out);
                s_data.push_back(bus.row_out);
                if (prev_valid || !bus.row_ready_in) prot_err++;
            end
            if (bus.mem_rd_en_out) begin
                r_cyc.push_back(cyc);
                r_addr.push_back(bus.mem_addr_out);
            end
            if (frame_done_out) fd_cyc.push_back(cyc);
            if (bus.row_ready_in && !prev_ready) rdy_rise = cyc;
            if (bus.row_valid_out) busy = busy_len - 1;
            else if (busy > 0) busy--;
        end
        prev_valid = bus.row_valid_out;
        prev_ready = bus.row_ready_in;
        nxt_ready  = !hold_low && (busy == 0);
    end

    task automatic clear_q();
        s_cyc.delete(); s_addr.delete(); s_data.delete();
        r_cyc.delete(); r_addr.delete();
    endtask

    task automatic get_strobe(output int c, output logic [3:0] a, output logic [RW-1:0] d, output bit to);
        int n = 0;
        to = 0; c = 0; a = '0; d = '0;
        while (s_cyc.size() == 0 && n < 2000) begin
            @(negedge clk_in); #1;
            n++;
        end
        if (s_cyc.size() == 0) to = 1;
        else begin
            c = s_cyc.pop_front(); a = s_addr.pop_front(); d = s_data.pop_front();
        end
    endtask

    function automatic int exp_gap(int p, int b);
        int t = BT << p;
        return ((t > b) ? t : b) + 1;
    endfunction

    task automatic test_reset();
        reset_in = 1'b1;
        repeat (3) @(posedge clk_in);
        #1;
        vectors += 6;
        if (bus.mem_rd_en_out !== 1'b0) begin miscompares++; $display("FAIL reset_rd_en got %b want 0", bus.mem_rd_en_out); end
        if (bus.mem_addr_out !== 6'd0) begin miscompares++; $display("FAIL reset_mem_addr got %h want 0", bus.mem_addr_out); end
        if (bus.row_valid_out !== 1'b0) begin miscompares++; $display("FAIL reset_row_valid got %b want 0", bus.row_valid_out); end
        if (bus.row_out !== '0) begin miscompares++; $display("FAIL reset_row_out got %h want 0", bus.row_out); end
        if (bus.row_address_out !== 4'd0) begin miscompares++; $display("FAIL reset_row_addr got %h want 0", bus.row_address_out); end
        if (frame_done_out !== 1'b0) begin miscompares++; $display("FAIL reset_frame_done got %b want 0", frame_done_out); end
        reset_in = 1'b0;
        repeat (4) @(posedge clk_in);
        #1;
        vectors++;
        if (bus.mem_rd_en_out !== 1'b0 || r_cyc.size() != 0) begin
            miscompares++; $display("FAIL idle_no_read got %0d reads want 0", r_cyc.size());
        end
    endtask

    task automatic test_first_row();
        int c, e; logic [3:0] a; logic [RW-1:0] d; bit to;
        @(posedge clk_in); #1;
        clear_q();
        enable_in = 1'b1;
        e = cyc;
        get_strobe(c, a, d, to);
        vectors += 5;
        if (to) begin miscompares++; $display("FAIL first_strobe_timeout got none want strobe"); end
        if (r_cyc.size() == 0 || r_cyc[0] != e + 1) begin
            miscompares++; $display("FAIL first_read_cycle got %0d want %0d", (r_cyc.size() != 0) ? r_cyc[0] - e : -1, 1);
        end
        if (r_addr.size() == 0 || r_addr[0] !== 6'd0) begin miscompares++; $display("FAIL first_read_addr got nonzero want 0"); end
        if (c != e + 3) begin miscompares++; $display("FAIL first_strobe_latency got %0d want 3", c - e); end
        if (a !== 4'd0 || d !== mem[0]) begin miscompares++; $display("FAIL first_row got %h/%h want 0/%h", a, d, mem[0]); end
        model_pos = 1; last_c = c; last_p = 0;
    endtask

    task automatic test_full_frame();
        int c, s63 = 0, fd0; logic [3:0] a; logic [RW-1:0] d; bit to;
        fd0 = fd_cyc.size();
        for (int k = 0; k < 66; k++) begin
            get_strobe(c, a, d, to);
            vectors++;
            if (to) begin miscompares++; $display("FAIL frame_timeout pos %0d got none want strobe", model_pos); break; end
            vectors += 2;
            if (a !== 4'(model_pos % NR) || d !== mem[model_pos]) begin
                miscompares++; $display("FAIL frame_row pos %0d got %h/%h want %h/%h", model_pos, a, d, model_pos % NR, mem[model_pos]);
            end
            if (c - last_c != exp_gap(last_p, busy_len)) begin
                miscompares++; $display("FAIL frame_spacing pos %0d got %0d want %0d", model_pos, c - last_c, exp_gap(last_p, busy_len));
            end
            if (model_pos == 63) s63 = c;
            last_c = c; last_p = model_pos / NR;
            model_pos = (model_pos + 1) % 64;
        end
        vectors += 2;
        if (fd_cyc.size() != fd0 + 1) begin miscompares++; $display("FAIL frame_done_count got %0d want 1", fd_cyc.size() - fd0); end
        else if (fd_cyc[fd0] != s63 + (BT << (NP - 1))) begin
            miscompares++; $display("FAIL frame_done_cycle got %0d want %0d", fd_cyc[fd0] - s63, BT << (NP - 1));
        end
    endtask

    task automatic test_busy_driver();
        int c; logic [3:0] a; logic [RW-1:0] d; bit to;
        for (int ph = 0; ph < 2; ph++) begin
            busy_len = (ph == 0) ? $urandom_range(2, 63) : $urandom_range(70, 400);
            for (int k = 0; k < 4; k++) begin
                get_strobe(c, a, d, to);
                vectors++;
                if (to) begin miscompares++; $display("FAIL busy_timeout pos %0d got none want strobe", model_pos); break; end
                vectors++;
                if (a !== 4'(model_pos % NR) || d !== mem[model_pos]) begin
                    miscompares++; $display("FAIL busy_row pos %0d got %h/%h want %h/%h", model_pos, a, d, model_pos % NR, mem[model_pos]);
                end
                if (k > 0) begin
                    vectors++;
                    if (c - last_c != exp_gap(last_p, busy_len)) begin
                        miscompares++; $display("FAIL busy_spacing busy %0d got %0d want %0d", busy_len, c - last_c, exp_gap(last_p, busy_len));
                    end
                end
                last_c = c; last_p = model_pos / NR;
                model_pos = (model_pos + 1) % 64;
            end
        end
    endtask

    task automatic test_ready_stall();
        int c; logic [3:0] a; logic [RW-1:0] d; bit to;
        hold_low = 1'b1;
        repeat (500) @(negedge clk_in);
        #1;
        vectors++;
        if (s_cyc.size() != 0) begin miscompares++; $display("FAIL stall_no_strobe got %0d want 0", s_cyc.size()); end
        hold_low = 1'b0;
        get_strobe(c, a, d, to);
        vectors += 3;
        if (to) begin miscompares++; $display("FAIL stall_timeout got none want strobe"); end
        if (c != rdy_rise + 1) begin miscompares++; $display("FAIL stall_release got %0d want 1", c - rdy_rise); end
        if (a !== 4'(model_pos % NR) || d !== mem[model_pos]) begin
            miscompares++; $display("FAIL stall_row got %h/%h want %h/%h", a, d, model_pos % NR, mem[model_pos]);
        end
        last_c = c; last_p = model_pos / NR;
        model_pos = (model_pos + 1) % 64;
    endtask

    task automatic test_enable_drop();
        int c, s = 0, e; logic [3:0] a; logic [RW-1:0] d; bit to, hit = 0;
        busy_len = 64;
        for (int k = 0; k < 64 && !hit; k++) begin
            get_strobe(c, a, d, to);
            vectors++;
            if (to) begin miscompares++; $display("FAIL drop_timeout pos %0d got none want strobe", model_pos); break; end
            vectors++;
            if (a !== 4'(model_pos % NR) || d !== mem[model_pos]) begin
                miscompares++; $display("FAIL drop_row pos %0d got %h/%h want %h/%h", model_pos, a, d, model_pos % NR, mem[model_pos]);
            end
            if (model_pos == 39) begin hit = 1; s = c; r_cyc.delete(); r_addr.delete(); end
            model_pos = (model_pos + 1) % 64;
        end
        if (!hit) return;
        repeat (40) @(posedge clk_in);
        #1;
        enable_in = 1'b0;
        do begin @(posedge clk_in); #1; end while (cyc < s + 300);
        vectors += 2;
        if (s_cyc.size() != 0) begin miscompares++; $display("FAIL drop_no_strobe got %0d want 0", s_cyc.size()); end
        if (r_cyc.size() != 1 || r_cyc[0] != s + 1) begin
            miscompares++; $display("FAIL drop_prefetch_only got %0d reads want 1", r_cyc.size());
        end
        clear_q();
        enable_in = 1'b1;
        e = cyc;
        get_strobe(c, a, d, to);
        vectors += 4;
        if (to) begin miscompares++; $display("FAIL resume_timeout got none want strobe"); end
        if (r_cyc.size() == 0 || r_cyc[0] != e + 1 || r_addr[0] !== 6'd40) begin
            miscompares++; $display("FAIL resume_read got %0d reads want addr 28 at +1", r_cyc.size());
        end
        if (c != e + 3) begin miscompares++; $display("FAIL resume_latency got %0d want 3", c - e); end
        if (a !== 4'd8 || d !== mem[40]) begin miscompares++; $display("FAIL resume_row got %h/%h want 8/%h", a, d, mem[40]); end
        model_pos = 41; last_c = c; last_p = 2;
    endtask

    task automatic test_reset_mid();
        int c, r; logic [3:0] a; logic [RW-1:0] d; bit to, hit = 0;
        @(posedge clk_in); #1;
        reset_in = 1'b1;
        repeat (2) @(posedge clk_in);
        #1;
        reset_in = 1'b0;
        clear_q();
        model_pos = 0;
        for (int k = 0; k < 24 && !hit; k++) begin
            get_strobe(c, a, d, to);
            vectors++;
            if (to) begin miscompares++; $display("FAIL rmid_timeout pos %0d got none want strobe", model_pos); break; end
            vectors++;
            if (a !== 4'(model_pos % NR) || d !== mem[model_pos]) begin
                miscompares++; $display("FAIL rmid_row pos %0d got %h/%h want %h/%h", model_pos, a, d, model_pos % NR, mem[model_pos]);
            end
            if (model_pos == 19) hit = 1;
            model_pos = (model_pos + 1) % 64;
        end
        if (!hit) return;
        vectors++;
        if (bus.row_valid_out !== 1'b1) begin miscompares++; $display("FAIL rmid_in_send got %b want 1", bus.row_valid_out); end
        reset_in = 1'b1;
        #1;
        vectors += 3;
        if (bus.row_valid_out !== 1'b0 || bus.mem_rd_en_out !== 1'b0 || frame_done_out !== 1'b0) begin
            miscompares++; $display("FAIL rmid_async_strobes got %b%b%b want 000", bus.row_valid_out, bus.mem_rd_en_out, frame_done_out);
        end
        if (bus.row_out !== '0) begin miscompares++; $display("FAIL rmid_async_row_out got %h want 0", bus.row_out); end
        if (bus.row_address_out !== 4'd0 || bus.mem_addr_out !== 6'd0) begin
            miscompares++; $display("FAIL rmid_async_addr got %h/%h want 0/0", bus.row_address_out, bus.mem_addr_out);
        end
        repeat (3) @(posedge clk_in);
        #1;
        clear_q();
        reset_in = 1'b0;
        r = cyc;
        get_strobe(c, a, d, to);
        vectors += 3;
        if (to) begin miscompares++; $display("FAIL rmid_restart_timeout got none want strobe"); end
        if (c != r + 3) begin miscompares++; $display("FAIL rmid_restart_latency got %0d want 3", c - r); end
        if (a !== 4'd0 || d !== mem[0]) begin miscompares++; $display("FAIL rmid_restart_row got %h/%h want 0/%h", a, d, mem[0]); end
    endtask

    task automatic test_protocol();
        vectors += 2;
        if (prot_err != 0) begin miscompares++; $display("FAIL strobe_protocol got %0d violations want 0", prot_err); end
        if (fd_cyc.size() != 1) begin miscompares++; $display("FAIL frame_done_total got %0d want 1", fd_cyc.size()); end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i] = {$urandom(), $urandom(), $urandom()};
            mem[i][7:0] = 8'(i);
        end
        test_reset();
        test_first_row();
        test_full_frame();
        test_busy_driver();
        test_ready_stall();
        test_enable_drop();
        test_reset_mid();
        test_protocol();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
